// File: rtl/cpu_pkg.sv
// Shared decode definitions for the 16-bit Thumb-subset core: ALU codes,
// register constants and the control bundle produced by the decoder.
package cpu_pkg;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_MV_IMM = 3'b001;
  localparam logic [2:0] ALU_MV_REG = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b101;

  localparam int REG_W = 4;
  localparam logic [REG_W-1:0] SP_IDX = 4'd13;

  typedef struct packed {
    logic [2:0]       alu_sel;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             rd_we;
    logic             imm_sel;
    logic             mem_rd;
    logic             mem_wr;
    logic             branch;
    logic             set_flags;
    logic             illegal;
    logic             uses_rs;
    logic             uses_rt;
  } id_ctrl_t;

endpackage

// File: rtl/id_decode_lut.sv
// Purely combinational Thumb-subset decoder: instruction word to control bundle.
// Shared with the disassembler monitor, so it carries no state.
module id_decode_lut
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output id_ctrl_t    o_ctrl
);

  always_comb begin
    // NOTE: o_ctrl gets a full default before the case so no path leaves a
    // field unassigned; that is what keeps this block from inferring latches.
    o_ctrl = '0;
    priority casez (i_ir[15:7])
      9'b0001110??: begin
        o_ctrl.alu_sel   = ALU_ADD;
        o_ctrl.rd        = {1'b0, i_ir[2:0]};
        o_ctrl.rs        = {1'b0, i_ir[5:3]};
        o_ctrl.uses_rs   = 1'b1;
        o_ctrl.rd_we     = 1'b1;
        o_ctrl.imm_sel   = 1'b1;
        o_ctrl.set_flags = 1'b1;
      end
      9'b101100001: begin
        o_ctrl.alu_sel = ALU_SUB;
        o_ctrl.rd      = SP_IDX;
        o_ctrl.rs      = SP_IDX;
        o_ctrl.uses_rs = 1'b1;
        o_ctrl.rd_we   = 1'b1;
        o_ctrl.imm_sel = 1'b1;
      end
      9'b00100????: begin
        o_ctrl.alu_sel   = ALU_MV_IMM;
        o_ctrl.rd        = {1'b0, i_ir[10:8]};
        o_ctrl.rd_we     = 1'b1;
        o_ctrl.imm_sel   = 1'b1;
        o_ctrl.set_flags = 1'b1;
      end
      9'b01000110?: begin
        o_ctrl.alu_sel = ALU_MV_REG;
        o_ctrl.rd      = {i_ir[7], i_ir[2:0]};
        o_ctrl.rs      = i_ir[6:3];
        o_ctrl.uses_rs = 1'b1;
        o_ctrl.rd_we   = 1'b1;
      end
      9'b01101????: begin
        o_ctrl.alu_sel = ALU_ADD;
        o_ctrl.rd      = {1'b0, i_ir[2:0]};
        o_ctrl.rs      = {1'b0, i_ir[5:3]};
        o_ctrl.uses_rs = 1'b1;
        o_ctrl.rd_we   = 1'b1;
        o_ctrl.imm_sel = 1'b1;
        o_ctrl.mem_rd  = 1'b1;
      end
      9'b01100????: begin
        o_ctrl.alu_sel = ALU_ADD;
        o_ctrl.rs      = {1'b0, i_ir[5:3]};
        o_ctrl.rt      = {1'b0, i_ir[2:0]};
        o_ctrl.uses_rs = 1'b1;
        o_ctrl.uses_rt = 1'b1;
        o_ctrl.imm_sel = 1'b1;
        o_ctrl.mem_wr  = 1'b1;
      end
      9'b1101?????: begin
        o_ctrl.alu_sel = ALU_ADD;
        o_ctrl.imm_sel = 1'b1;
        o_ctrl.branch  = 1'b1;
      end
      9'b00101????: begin
        o_ctrl.alu_sel   = ALU_SUB;
        o_ctrl.rs        = {1'b0, i_ir[10:8]};
        o_ctrl.uses_rs   = 1'b1;
        o_ctrl.imm_sel   = 1'b1;
        o_ctrl.set_flags = 1'b1;
      end
      default: begin
        o_ctrl.alu_sel = ALU_MV_IMM;
        o_ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// ID pipeline stage: registers the decoded bundle between IF and EX with
// valid/ready handshakes, branch flush, load-use bubble and bubble counter.
module id_decode_stage
  import cpu_pkg::*;
#(
  parameter int IR_W           = 16,
  parameter int REG_AW         = 4,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IR_W-1:0]   i_ir,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_ready,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [IR_W-1:0]   o_ir,
  output logic [2:0]        o_alu_sel,
  output logic [REG_AW-1:0] o_rd,
  output logic [REG_AW-1:0] o_rs,
  output logic [REG_AW-1:0] o_rt,
  output logic              o_rd_we,
  output logic              o_imm_sel,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_branch,
  output logic              o_set_flags,
  output logic              o_illegal,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  if (IR_W != 16) begin : g_bad_ir_w
    $error("id_decode_stage: IR_W must be 16");
  end

  id_ctrl_t dec;
  logic     adv;
  logic     src_hit;
  logic     haz;

  id_decode_lut u_lut (
    .i_ir  (i_ir[15:0]),
    .o_ctrl(dec)
  );

  // The held LDR's destination is compared only against sources the new
  // instruction actually reads, so unused register fields never stall.
  assign src_hit = (dec.uses_rs && (o_rd == REG_AW'(dec.rs))) ||
                   (dec.uses_rt && (o_rd == REG_AW'(dec.rt)));
  assign adv     = !o_valid || i_ready;
  assign haz     = (LOAD_USE_STALL != 0) && i_valid && o_valid &&
                   o_mem_rd && o_rd_we && src_hit;
  assign o_ready = adv && !haz && !i_flush;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      o_valid      <= 1'b0;
      o_ir         <= '0;
      o_alu_sel    <= ALU_MV_IMM;
      o_rd         <= '0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd_we      <= 1'b0;
      o_imm_sel    <= 1'b0;
      o_mem_rd     <= 1'b0;
      o_mem_wr     <= 1'b0;
      o_branch     <= 1'b0;
      o_set_flags  <= 1'b0;
      o_illegal    <= 1'b0;
      o_bubble_cnt <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (!adv) begin
      o_valid <= o_valid;
    end else if (haz) begin
      // The LDR leaves on this edge, so the hazard cannot persist.
      o_valid <= 1'b0;
      if (o_bubble_cnt != '1) o_bubble_cnt <= o_bubble_cnt + 1'b1;
    end else if (i_valid) begin
      o_valid     <= 1'b1;
      o_ir        <= i_ir;
      o_alu_sel   <= dec.alu_sel;
      o_rd        <= REG_AW'(dec.rd);
      o_rs        <= REG_AW'(dec.rs);
      o_rt        <= REG_AW'(dec.rt);
      o_rd_we     <= dec.rd_we;
      o_imm_sel   <= dec.imm_sel;
      o_mem_rd    <= dec.mem_rd;
      o_mem_wr    <= dec.mem_wr;
      o_branch    <= dec.branch;
      o_set_flags <= dec.set_flags;
      if (dec.illegal) o_illegal <= 1'b1;
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule
